// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the Wishbone / capture-stream SRAM port arbiter.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_ACK,
    WR_REQ,
    RMW_RD,
    RMW_MERGE,
    ACK
  } arb_state_e;

  localparam int WB_WORD_LSB = 2;

  // Per-byte select: take the new byte where sel is set, keep the old one otherwise.
  function automatic logic [31:0] byte_merge(input logic [3:0]  sel,
                                             input logic [31:0] new_w,
                                             input logic [31:0] old_w);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) begin
      w[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return w;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_ring.sv
// Capture ring-buffer pointer: advances on every accepted stream beat, pulses on wrap.
module sram_ring_writer #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= beat && (wr_ptr == LAST_ADDR);
      if (beat) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Wishbone window onto a 1R1W SRAM with byte-masked RMW, sharing the write port
// with a capture stream; WB writes may lose to the stream for at most STARVE_MAX cycles.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int          ADDR_W     = 8,
  parameter int          DATA_W     = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          STARVE_MAX = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              cap_en_i,
  input  logic              st_valid_i,
  input  logic [DATA_W-1:0] st_data_i,
  output logic              st_ready_o,
  output logic [ADDR_W-1:0] wr_ptr_o,
  output logic              frame_done_o,
  output logic [ADDR_W-1:0] mem_raddr_o,
  output logic              mem_ren_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic              mem_wen_o,
  output logic [DATA_W-1:0] mem_wdata_o
);

  localparam int                TAG_LSB    = ADDR_W + WB_WORD_LSB;
  localparam int                SC_W       = $clog2(STARVE_MAX + 2);
  localparam logic [SC_W-1:0]   STARVE_LIM = SC_W'(STARVE_MAX);

  arb_state_e        state_q, state_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic              rmw_q, rmw_d;
  logic [31:0]       rd_dat_q;
  logic [ADDR_W-1:0] waddr_p0;
  logic [DATA_W-1:0] old_p1;
  logic [DATA_W-1:0] merged_p2;

  logic              wb_hit;
  logic [ADDR_W-1:0] wb_word;
  logic              st_ready;
  logic              st_beat;
  logic              rd_hazard;
  logic              starved;
  logic              wb_grant;
  logic              rd_issue;
  logic [ADDR_W-1:0] wr_ptr;
  logic              unused_adr_bits;

  assign unused_adr_bits = ^wbs_adr_i[WB_WORD_LSB-1:0];

  assign wb_hit  = wbs_cyc_i & wbs_stb_i &
                   (wbs_adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign wb_word = wbs_adr_i[TAG_LSB-1:WB_WORD_LSB];

  // The stream yields the write port to a reserved RMW or a fully starved WB write.
  assign starved   = (state_q == WR_REQ) && (starve_q == STARVE_LIM);
  assign st_ready  = ~wb_rst_i & cap_en_i & ~rmw_q & ~starved;
  assign st_beat   = st_valid_i & st_ready;
  assign rd_hazard = st_beat && (wr_ptr == wb_word);
  assign wb_grant  = ~wb_rst_i & (state_q == WR_REQ) & (~st_beat | starved | rmw_q);

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    rmw_d    = rmw_q;
    rd_issue = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wb_hit) begin
          if (!wbs_we_i) begin
            if (!rd_hazard) begin
              rd_issue = 1'b1;
              state_d  = RD_WAIT;
            end
          end else if (wbs_sel_i == 4'hF) begin
            state_d = WR_REQ;
          end else if (wbs_sel_i == 4'h0) begin
            state_d = ACK;
          end else if (!rd_hazard) begin
            rd_issue = 1'b1;
            rmw_d    = 1'b1;
            state_d  = RMW_RD;
          end
        end
      end
      RD_WAIT:   state_d = RD_ACK;
      RD_ACK:    state_d = IDLE;
      RMW_RD:    state_d = RMW_MERGE;
      RMW_MERGE: state_d = WR_REQ;
      WR_REQ: begin
        if (wb_grant) begin
          starve_d = '0;
          rmw_d    = 1'b0;
          state_d  = ACK;
        end else begin
          starve_d = starve_q + 1'b1;
        end
      end
      ACK:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      starve_q <= '0;
      rmw_q    <= 1'b0;
      rd_dat_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      rmw_q    <= rmw_d;
      if (state_q == RD_WAIT) begin
        rd_dat_q <= mem_rdata_i;
      end
    end
  end

  // p0: accepted word address; p1: old word from the RMW read; p2: merged write word
  always_ff @(posedge wb_clk_i) begin
    if (state_q == IDLE) begin
      waddr_p0 <= wb_word;
    end
    if (state_q == RMW_RD) begin
      old_p1 <= mem_rdata_i;
    end
    if (state_q == RMW_MERGE) begin
      merged_p2 <= byte_merge(wbs_sel_i, wbs_dat_i, old_p1);
    end
  end

  sram_ring_writer #(
    .ADDR_W(ADDR_W)
  ) u_ring (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .beat       (st_beat),
    .wr_ptr     (wr_ptr),
    .frame_done (frame_done_o)
  );

  assign wbs_ack_o   = ~wb_rst_i & ((state_q == RD_ACK) | (state_q == ACK));
  assign wbs_dat_o   = rd_dat_q;
  assign st_ready_o  = st_ready;
  assign wr_ptr_o    = wr_ptr;

  assign mem_ren_o   = ~wb_rst_i & rd_issue;
  assign mem_raddr_o = mem_ren_o ? wb_word : '0;

  assign mem_wen_o   = wb_grant | st_beat;
  assign mem_waddr_o = wb_grant ? waddr_p0 : (st_beat ? wr_ptr : '0);
  assign mem_wdata_o = wb_grant ? (rmw_q ? merged_p2 : wbs_dat_i)
                                : (st_beat ? st_data_i : '0);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: stimulus queues expectations, a negedge monitor checks them.
module tb_sram_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        wb_rst_i, wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
  logic        wbs_ack_o;
  logic        cap_en_i, st_valid_i, st_ready_o, frame_done_o;
  logic [31:0] st_data_i;
  logic [7:0]  wr_ptr_o, mem_raddr_o, mem_waddr_o;
  logic        mem_ren_o, mem_wen_o;
  logic [31:0] mem_rdata_i, mem_wdata_o;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .ADDR_W(8), .DATA_W(32), .BASE_ADDR(32'h3000_0000), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .cap_en_i(cap_en_i), .st_valid_i(st_valid_i), .st_data_i(st_data_i),
    .st_ready_o(st_ready_o), .wr_ptr_o(wr_ptr_o), .frame_done_o(frame_done_o),
    .mem_raddr_o(mem_raddr_o), .mem_ren_o(mem_ren_o), .mem_rdata_i(mem_rdata_i),
    .mem_waddr_o(mem_waddr_o), .mem_wen_o(mem_wen_o), .mem_wdata_o(mem_wdata_o)
  );

  // SRAM macro model with a preload port
  logic [31:0] mem [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  logic [31:0] rdata_q = '0;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_wen_o) mem[mem_waddr_o] <= mem_wdata_o;
    if (mem_ren_o) rdata_q <= mem[mem_raddr_o];
  end
  assign mem_rdata_i = rdata_q;

  int cyc_n = 0;
  bit rst_q = 1'b0;
  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    rst_q <= wb_rst_i;
  end

  typedef struct { logic [7:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int lo; int hi; bit chk_dat; logic [31:0] dat; } ack_t;
  typedef struct { int kind; int exp; } probe_t;

  wr_t         exp_st[$];
  wr_t         exp_wb[$];
  logic [7:0]  exp_rd[$];
  ack_t        exp_ack[$];
  probe_t      probes[$];
  logic [31:0] st_src[$];

  int   n_chk = 0, n_pass = 0;
  int   ack_cnt = 0, wbw_cnt = 0, rd_cnt = 0;
  bit   wrap_prev = 1'b0;
  bit   rmw_win = 1'b0;
  logic [7:0] m_ptr = '0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
  endfunction

  // Monitor: the only process that compares
  always @(negedge clk) begin
    bit     beat, wrap_now, have;
    wr_t    w;
    ack_t   a;
    probe_t p;
    wrap_now = 1'b0;
    beat = st_valid_i && st_ready_o;
    if (rst_q && wb_rst_i) begin
      chk("reset_ctl", 32'({wbs_ack_o, mem_ren_o, mem_wen_o, st_ready_o, frame_done_o, wr_ptr_o}), 32'd0);
      chk("reset_rdata", wbs_dat_o, 32'd0);
    end
    if (rmw_win) chk("rmw_st_ready", 32'(st_ready_o), 32'd0);
    if (beat) begin
      chk("beat_wen", 32'(mem_wen_o), 32'd1);
      have = exp_st.size() > 0;
      chk("stream_beat_expected", 32'(have), 32'd1);
      if (have) begin
        w = exp_st.pop_front();
        chk("stream_addr", 32'(mem_waddr_o), 32'(w.addr));
        chk("stream_data", mem_wdata_o, w.data);
        wrap_now = (w.addr == 8'hFF);
      end
    end else if (mem_wen_o) begin
      wbw_cnt++;
      have = exp_wb.size() > 0;
      chk("wb_write_expected", 32'(have), 32'd1);
      if (have) begin
        w = exp_wb.pop_front();
        chk("wb_write_addr", 32'(mem_waddr_o), 32'(w.addr));
        chk("wb_write_data", mem_wdata_o, w.data);
      end
    end
    if (frame_done_o || wrap_prev) chk("frame_done", 32'(frame_done_o), 32'(wrap_prev));
    wrap_prev = wrap_now;
    if (mem_ren_o) begin
      rd_cnt++;
      have = exp_rd.size() > 0;
      chk("read_expected", 32'(have), 32'd1);
      if (have) chk("read_addr", 32'(mem_raddr_o), 32'(exp_rd.pop_front()));
    end
    if (wbs_ack_o) begin
      ack_cnt++;
      have = exp_ack.size() > 0;
      chk("ack_expected", 32'(have), 32'd1);
      if (have) begin
        a = exp_ack.pop_front();
        if (a.lo == a.hi) chk("ack_cycle", 32'(cyc_n), 32'(a.lo));
        else chk("ack_in_window", 32'(cyc_n >= a.lo && cyc_n <= a.hi), 32'd1);
        if (a.chk_dat) chk("rd_data", wbs_dat_o, a.dat);
      end
    end
    while (probes.size() > 0) begin
      p = probes.pop_front();
      case (p.kind)
        0: chk("wr_ptr", 32'(wr_ptr_o), 32'(p.exp));
        1: chk("ack_count", 32'(ack_cnt), 32'(p.exp));
        2: chk("wb_write_count", 32'(wbw_cnt), 32'(p.exp));
        3: chk("read_count", 32'(rd_cnt), 32'(p.exp));
        default: chk("pending_expectations",
                     32'(exp_st.size() + exp_wb.size() + exp_rd.size() + exp_ack.size()), 32'(p.exp));
      endcase
    end
  end

  // Stream source: presents the queue head, advances only on an accepted beat
  initial begin
    bit b;
    st_valid_i = 1'b0;
    st_data_i  = '0;
    forever begin
      @(negedge clk);
      b = st_valid_i && st_ready_o;
      @(posedge clk);
      #1;
      if (b && st_src.size() > 0) void'(st_src.pop_front());
      if (st_src.size() > 0) begin
        st_valid_i = 1'b1;
        st_data_i  = st_src[0];
      end else begin
        st_valid_i = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick(1);
    pl_en = 1'b0;
  endtask

  task automatic stream_push(input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      st_src.push_back(base + 32'(k));
      exp_st.push_back('{m_ptr, base + 32'(k)});
      m_ptr = m_ptr + 8'd1;
    end
  endtask

  task automatic wb_start(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                          input logic [31:0] dat, output int c);
    wbs_adr_i = adr; wbs_we_i = we; wbs_sel_i = sel; wbs_dat_i = dat;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    c = cyc_n;
  endtask

  task automatic wb_end();
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wait_acks(input int n);
    for (int i = 0; i < 40 && ack_cnt < n; i++) tick(1);
    probes.push_back('{1, n});
  endtask

  task automatic wait_drain(input int lim);
    for (int i = 0; i < lim && st_src.size() > 0; i++) tick(1);
    tick(2);
    probes.push_back('{0, int'(m_ptr)});
  endtask

  initial begin
    int c;
    wb_rst_i = 1'b1; cap_en_i = 1'b1;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0;
    tick(3);
    wb_rst_i = 1'b0;
    tick(1);

    // Plain read, two-cycle latency, single ack
    preload(8'd4, 32'hDEAD_BEEF);
    wb_start(32'h3000_0010, 1'b0, 4'hF, '0, c);
    exp_rd.push_back(8'd4);
    exp_ack.push_back('{c + 2, c + 2, 1'b1, 32'hDEAD_BEEF});
    wait_acks(1);
    wb_end();
    tick(3);
    probes.push_back('{1, 1});

    // Byte-masked write while the stream is running
    preload(8'd4, 32'hAABB_CCDD);
    stream_push(12, 32'hC000_0000);
    wb_start(32'h3000_0010, 1'b1, 4'b0101, 32'h1122_3344, c);
    exp_rd.push_back(8'd4);
    exp_wb.push_back('{8'd4, 32'hAA22_CC44});
    exp_ack.push_back('{c + 4, c + 4, 1'b0, '0});
    tick(1);
    rmw_win = 1'b1;
    tick(3);
    rmw_win = 1'b0;
    wait_acks(2);
    wb_end();
    wait_drain(100);

    // Full write under continuous stream pressure
    stream_push(20, 32'hD000_0000);
    tick(3);
    wb_start(32'h3000_0190, 1'b1, 4'hF, 32'h1234_5678, c);
    exp_wb.push_back('{8'd100, 32'h1234_5678});
    exp_ack.push_back('{c + 2 + STARVE_MAX, c + 2 + STARVE_MAX, 1'b0, '0});
    wait_acks(3);
    wb_end();
    wait_drain(100);
    probes.push_back('{2, 2});

    // Out-of-window read is ignored
    wb_start(32'h3000_0400, 1'b0, 4'hF, '0, c);
    tick(6);
    wb_end();
    tick(1);
    probes.push_back('{1, 3});
    probes.push_back('{3, 2});

    // Write with no byte selects: ack only, no memory traffic
    wb_start(32'h3000_001C, 1'b1, 4'h0, 32'hFFFF_FFFF, c);
    exp_ack.push_back('{c + 1, c + 2, 1'b0, '0});
    wait_acks(4);
    wb_end();
    tick(2);
    probes.push_back('{2, 2});
    probes.push_back('{3, 2});

    // Reset in the middle of a read-modify-write
    preload(8'd200, 32'h0BAD_F00D);
    wb_start(32'h3000_0028, 1'b1, 4'b0011, 32'h5566_7788, c);
    exp_rd.push_back(8'd10);
    tick(2);
    wb_rst_i = 1'b1;
    wb_end();
    tick(2);
    wb_rst_i = 1'b0;
    m_ptr = '0;
    tick(1);
    probes.push_back('{0, 0});
    probes.push_back('{1, 4});
    probes.push_back('{2, 2});
    wb_start(32'h3000_0320, 1'b0, 4'hF, '0, c);
    exp_rd.push_back(8'd200);
    exp_ack.push_back('{c + 2, c + 2, 1'b1, 32'h0BAD_F00D});
    wait_acks(5);
    wb_end();
    tick(2);

    // One full ring lap from address 0
    stream_push(256, 32'h5000_0000);
    wait_drain(400);

    // Capture disabled holds the pointer, then resumes from it
    cap_en_i = 1'b0;
    stream_push(3, 32'h6000_0000);
    tick(6);
    probes.push_back('{0, 0});
    cap_en_i = 1'b1;
    wait_drain(50);

    tick(2);
    probes.push_back('{4, 0});
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Sits between the Caravel Wishbone slave port / a streaming sample source and the 256x32 dual-port SRAM macro (one read port, one write port).
- Decodes a Wishbone address window and performs word reads, full-word writes and byte-masked writes (read-modify-write).
- Arbitrates the single SRAM write port between Wishbone and a capture stream that writes an auto-incrementing ring buffer.

Parameters:
- ADDR_W, 8, SRAM word-address width (depth = 2**ADDR_W)
- DATA_W, 32, SRAM word width
- BASE_ADDR, 32'h3000_0000, Wishbone window base (byte address)
- STARVE_MAX, 4, max consecutive cycles a pending WB write may lose the write port to the stream

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  synchronous reset, active-high
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe/cycle/write
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  ack, one-cycle pulse
- wbs_dat_o  out  32  read data, registered
- cap_en_i  in  1  capture enable
- st_valid_i  in  1  stream sample valid
- st_data_i  in  DATA_W  stream sample
- st_ready_o  out  1  stream accepted this cycle when high with st_valid_i
- wr_ptr_o  out  ADDR_W  next capture address
- frame_done_o  out  1  one-cycle pulse on the ring wrap write
- mem_raddr_o  out  ADDR_W  SRAM read address
- mem_ren_o  out  1  SRAM read enable, active-high
- mem_rdata_i  in  DATA_W  SRAM read data, valid the cycle after mem_ren_o
- mem_waddr_o  out  ADDR_W  SRAM write address
- mem_wen_o  out  1  SRAM write enable, active-high
- mem_wdata_o  out  DATA_W  SRAM write data

Behaviour:
- Reset (sync, wb_rst_i=1): FSM to IDLE; starve_cnt, wr_ptr to 0; all outputs 0. Any in-flight WB transaction is dropped without ack.
- Decode: hit = cyc&stb & (adr[31:ADDR_W+2]==BASE_ADDR[31:ADDR_W+2]); word addr = adr[ADDR_W+1:2]. Misses are ignored (never acked).
- FSM states: IDLE, RD_WAIT, RD_ACK, WR_REQ, RMW_RD, RMW_MERGE, ACK.
- IDLE: on hit:
  - read -> issue mem_ren_o -> RD_WAIT.
  - write with sel==4'hF -> WR_REQ.
  - write with sel==0 -> ACK (no memory access).
  - other write -> issue mem_ren_o at word addr -> RMW_RD.
- RD_WAIT: capture mem_rdata_i into wbs_dat_o -> RD_ACK. RD_ACK: wbs_ack_o=1 -> IDLE. Read latency: ack 2 cycles after stb sampled in IDLE.
- RMW_RD: capture mem_rdata_i -> RMW_MERGE. RMW_MERGE: merged = per-byte sel ? wbs_dat_i : old -> WR_REQ.
  - The write port is reserved from RMW_RD entry until the write commits; st_ready_o=0 throughout.
- WR_REQ: write granted if no stream beat this cycle, or starve_cnt==STARVE_MAX, or RMW reservation. On grant: mem_wen_o=1, data = wbs_dat_i or merged word; starve_cnt<=0 -> ACK. Otherwise starve_cnt++.
- ACK: wbs_ack_o=1 for exactly one cycle -> IDLE. A request still asserted in that cycle is not re-sampled.
- Stream:
  - st_ready_o = cap_en_i & ~rmw_reserved & ~(FSM==WR_REQ & starve_cnt==STARVE_MAX).
  - Beat (valid&ready): write st_data_i at wr_ptr; wr_ptr++ mod 2**ADDR_W.
  - frame_done_o=1 in the cycle after the write at address 2**ADDR_W-1.
  - cap_en_i low holds wr_ptr; it does not reset it.
- Read/write same address same cycle: the WB read is stalled one cycle (mem_ren_o deferred). Old data is never returned for a just-committed write.
- Stream reads and WB reads share nothing; only the write port is arbitrated.
- At most one of WB write / stream write drives mem_w* per cycle. mem_w* are combinational from registered state; mem_r* are driven in the issue cycle.

Decomposition:
- Package sram_arb_pkg: FSM state enum; WB_WORD_LSB=2 constant; a byte-merge function (sel, new, old) -> word.
- Sub-module sram_ring_writer: wr_ptr, wrap detection and frame_done pulse; takes grant, emits address and pulse.

Test Plan:
- WB read at 0x3000_0010 with mem word 4 = 0xDEADBEEF -> ack 2 cycles after stb, wbs_dat_o=0xDEADBEEF, exactly one ack.
- WB write sel=4'b0101, data 0x11223344 to word 4 holding 0xAABBCCDD -> RMW read then one write of 0xAA22CC44; no stream beat is accepted during the RMW.
- Continuous stream valid with cap_en_i=1 plus WB full write -> WB write commits within STARVE_MAX+1 cycles; st_ready_o low exactly in the grant cycle; no sample lost or duplicated.
- 256 stream beats from wr_ptr=0 -> writes to addr 0..255, one frame_done_o pulse after addr 255, wr_ptr back to 0.
- Address 0x3000_0400 (outside window) -> no ack and no memory access. WB write sel=0 -> ack in 2 cycles, mem_wen_o never set.
- wb_rst_i asserted during RMW_MERGE -> no ack, mem_wen_o=0 next cycle, wr_ptr=0; a subsequent read completes normally.
